// File: rtl/spw_fifo_param.sv
// spw_fifo_param: parametrised single-clock SpaceWire N-char FIFO.
// Tracks fill level and complete packets (EOP/EEP markers), with sticky
// overflow/underflow flags. Defining SPW_FIFO_STORE_FWD_EN enables
// store-and-forward: reads stall until a whole packet is buffered, unless
// the FIFO fills without a marker (drain mode, prevents deadlock).
module spw_fifo_param #(
  parameter int DATA_W    = 9,
  parameter int ADDR_W    = 6,
  parameter int AFULL_THR = 56
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic [ADDR_W:0]   counter,
  output logic [ADDR_W:0]   pkt_count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_C = AFULL_THR[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt, pkt;
  logic              wr_ok, rd_ok, wr_mark, rd_mark;

  // EOP (0x00) and EEP (0x01) with the control flag set delimit packets
  function automatic logic is_marker(input logic [DATA_W-1:0] d);
    return d[DATA_W-1] && (d[7:0] == 8'h00 || d[7:0] == 8'h01);
  endfunction

  assign full        = (cnt == DEPTH_C);
  assign almost_full = (cnt >= AFULL_C);
  assign counter     = cnt;
  assign pkt_count   = pkt;

  // flush overrides any transfer in the same cycle
  assign wr_ok   = wr_en && !full && !flush;
  assign rd_ok   = rd_en && !empty && !flush;
  assign wr_mark = is_marker(wr_data);
  assign rd_mark = is_marker(mem[rd_ptr]);

`ifdef SPW_FIFO_STORE_FWD_EN
  logic drain;

  assign empty = (cnt == '0) || (pkt == '0 && !drain);

  // drain lets a marker-less full FIFO empty out; ends at the next marker read
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     drain <= 1'b0;
    else if (flush)                drain <= 1'b0;
    else if (rd_ok && rd_mark)     drain <= 1'b0;
    else if (full && pkt == '0)    drain <= 1'b1;
  end
`else
  assign empty = (cnt == '0);
`endif

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // pointers, fill level and packet count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      pkt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      pkt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      case ({wr_ok && wr_mark, rd_ok && rd_mark})
        2'b10:   pkt <= pkt + 1'b1;
        2'b01:   pkt <= pkt - 1'b1;
        default: pkt <= pkt;
      endcase
    end
  end

  // registered read port, holds value between accepted reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_ok) rd_data <= mem[rd_ptr];
  end

  // sticky error flags; a new event beats err_clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)       overflow <= 1'b1;
      else if (err_clr)        overflow <= 1'b0;
      if (rd_en && empty)      underflow <= 1'b1;
      else if (err_clr)        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spw_fifo_param.sv
// Bench for spw_fifo_param: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_spw_fifo_param;

  localparam int DW    = 9;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int AFT   = 56;

  logic          clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full, almost_full, empty, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [AW:0]   counter, pkt_count;

  spw_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_THR(AFT)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
    .counter(counter), .pkt_count(pkt_count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  logic          m_ovf, m_udf, m_drain;

`ifdef SPW_FIFO_STORE_FWD_EN
  localparam bit SF = 1'b1;
`else
  localparam bit SF = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_mk(input logic [DW-1:0] d);
    return d[DW-1] && (d[7:0] == 8'h00 || d[7:0] == 8'h01);
  endfunction

  function automatic int m_pkt();
    int n = 0;
    foreach (q[i]) if (is_mk(q[i])) n++;
    return n;
  endfunction

  function automatic bit m_empty();
    return q.size() == 0 || (SF && m_pkt() == 0 && !m_drain);
  endfunction

  task automatic cmp_model(input string tag);
    chk({tag, ".counter"},     32'(counter),     32'(q.size()));
    chk({tag, ".pkt_count"},   32'(pkt_count),   32'(m_pkt()));
    chk({tag, ".empty"},       32'(empty),       32'(m_empty()));
    chk({tag, ".full"},        32'(full),        32'(q.size() == DEPTH));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= AFT));
    chk({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
    chk({tag, ".underflow"},   32'(underflow),   32'(m_udf));
    chk({tag, ".rd_data"},     32'(rd_data),     32'(m_rd));
  endtask

  function automatic void model_clear();
    q.delete();
    m_rd = '0; m_ovf = 1'b0; m_udf = 1'b0; m_drain = 1'b0;
  endfunction

  // apply one cycle of inputs, advance the model, compare after the edge
  task automatic step(input logic f, input logic w, input logic r, input logic c,
                      input logic [DW-1:0] d, input bool_cmp = 1'b1, input string tag = "step");
    bit full_b, emp_b;
    int pk;
    flush = f; wr_en = w; rd_en = r; err_clr = c; wr_data = d;
    full_b = (q.size() == DEPTH);
    emp_b  = m_empty();
    pk     = m_pkt();
    if (w && full_b) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && emp_b)  m_udf = 1'b1; else if (c) m_udf = 1'b0;
    if (f) begin
      q.delete();
      m_drain = 1'b0;
    end else begin
      if (SF && full_b && pk == 0) m_drain = 1'b1;
      if (r && !emp_b) begin
        m_rd = q.pop_front();
        if (is_mk(m_rd)) m_drain = 1'b0;
      end
      if (w && !full_b) q.push_back(d);
    end
    @(posedge clk); #1;
    if (bool_cmp) cmp_model(tag);
  endtask

  task automatic idle(input string tag = "idle");
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, tag);
  endtask

  task automatic do_reset();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic f, w, r, c;
    logic [DW-1:0] d;
    int cnt, pkt;
    logic e_ct, e_sf, ovf, udf;
    logic [DW-1:0] rdd;
  } vec_t;

  vec_t tbl[15];

  initial begin
    vec_t v;
    logic [DW-1:0] d;
    int k;

    tbl[0]  = '{1'b0,1'b0,1'b1,1'b0, 9'h000, 0,0, 1'b1,1'b1, 1'b0,1'b1, 9'h000};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b1, 9'h000, 0,0, 1'b1,1'b1, 1'b0,1'b0, 9'h000};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0, 9'h041, 1,0, 1'b0,1'b1, 1'b0,1'b0, 9'h000};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0, 9'h042, 2,0, 1'b0,1'b1, 1'b0,1'b0, 9'h000};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0, 9'h100, 3,1, 1'b0,1'b0, 1'b0,1'b0, 9'h000};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0, 9'h000, 2,1, 1'b0,1'b0, 1'b0,1'b0, 9'h041};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b0, 9'h000, 1,1, 1'b0,1'b0, 1'b0,1'b0, 9'h042};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b0, 9'h000, 0,0, 1'b1,1'b1, 1'b0,1'b0, 9'h100};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0, 9'h102, 1,0, 1'b0,1'b1, 1'b0,1'b0, 9'h100};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b0, 9'h101, 2,1, 1'b0,1'b0, 1'b0,1'b0, 9'h100};
    tbl[10] = '{1'b0,1'b1,1'b1,1'b0, 9'h1FF, 2,1, 1'b0,1'b0, 1'b0,1'b0, 9'h102};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b0, 9'h000, 1,0, 1'b0,1'b1, 1'b0,1'b0, 9'h101};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b0, 9'h100, 0,0, 1'b1,1'b1, 1'b0,1'b0, 9'h101};
    tbl[13] = '{1'b0,1'b1,1'b0,1'b0, 9'h000, 1,0, 1'b0,1'b1, 1'b0,1'b0, 9'h101};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b0, 9'h000, 0,0, 1'b1,1'b1, 1'b0,1'b0, 9'h101};

    // reset values
    #1;
    do_reset();
    chk("rst.counter", 32'(counter), 0);
    chk("rst.pkt", 32'(pkt_count), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.rd_data", 32'(rd_data), 0);

    // vector table
    for (int i = 0; i < 15; i++) begin
      v = tbl[i];
      step(v.f, v.w, v.r, v.c, v.d, 1'b1, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.counter", i), 32'(counter), 32'(v.cnt));
      chk($sformatf("tbl%0d.pkt", i), 32'(pkt_count), 32'(v.pkt));
      chk($sformatf("tbl%0d.empty", i), 32'(empty), 32'(SF ? v.e_sf : v.e_ct));
      chk($sformatf("tbl%0d.ovf", i), 32'(overflow), 32'(v.ovf));
      chk($sformatf("tbl%0d.udf", i), 32'(underflow), 32'(v.udf));
      chk($sformatf("tbl%0d.rd_data", i), 32'(rd_data), 32'(v.rdd));
    end

    // reset in the middle of traffic
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 9'(i + 1));
    chk("mid.counter_pre", 32'(counter), 10);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("mid.counter", 32'(counter), 0);
    chk("mid.empty", 32'(empty), 1);
    chk("mid.full", 32'(full), 0);
    chk("mid.pkt", 32'(pkt_count), 0);
    reset = 1'b0;
    model_clear();

    // fill to full, one write too many, read back in order
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, (i == DEPTH - 1) ? 9'h100 : 9'(i), 1'b1, "fill");
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'h0EE, 1'b1, "over");
    chk("over.full", 32'(full), 1);
    chk("over.counter", 32'(counter), 64);
    chk("over.ovf", 32'(overflow), 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "drainout");
      chk("order.rd_data", 32'(rd_data), (i == DEPTH - 1) ? 32'h100 : 32'(i));
    end
    chk("order.empty", 32'(empty), 1);

    // simultaneous read+write at full, then at empty
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b1, "clr");
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, (i == DEPTH - 1) ? 9'h100 : 9'(i + 3), 1'b1, "fill2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 9'h055, 1'b1, "fullrw");
    chk("fullrw.counter", 32'(counter), 63);
    chk("fullrw.ovf", 32'(overflow), 1);
    chk("fullrw.rd_data", 32'(rd_data), 3);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "empt");
    chk("empt.empty", 32'(empty), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 9'h100, 1'b1, "emptyrw");
    chk("emptyrw.counter", 32'(counter), 1);
    chk("emptyrw.udf", 32'(underflow), 1);
    chk("emptyrw.rd_data", 32'(rd_data), 32'h100);

`ifdef SPW_FIFO_STORE_FWD_EN
    // store-and-forward: held until the marker arrives
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'h0AA, 1'b1, "sf");
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'h0BB, 1'b1, "sf");
    chk("sf.empty_hold", 32'(empty), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'h101, 1'b1, "sf");
    chk("sf.empty_rel", 32'(empty), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "sf"); chk("sf.rd0", 32'(rd_data), 32'h0AA);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "sf"); chk("sf.rd1", 32'(rd_data), 32'h0BB);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "sf"); chk("sf.rd2", 32'(rd_data), 32'h101);

    // marker-less full FIFO must still drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 9'(i), 1'b1, "dr");
    idle("dr");
    chk("dr.empty", 32'(empty), 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "dr");
      chk("dr.rd_data", 32'(rd_data), 32'(i));
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'h011, 1'b1, "dr");
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, "dr");
    chk("dr.flush", 32'(counter), 0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit ph, f, w, r, c;
      ph = ((i / 150) % 2) == 1;
      w  = ($urandom % 100) < (ph ? 75 : 30);
      r  = ($urandom % 100) < (ph ? 30 : 75);
      f  = ($urandom % 250) == 0;
      c  = ($urandom % 40) == 0;
      if (f) begin w = 1'b0; r = 1'b0; end
      k = $urandom % 10;
      if (k < 2)       d = {1'b1, 7'h00, 1'($urandom)};
      else if (k == 2) d = {1'b1, 8'(($urandom % 254) + 2)};
      else             d = {1'b0, 8'($urandom)};
      step(f, w, r, c, d, 1'b1, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
